// File: rtl/counter_8b_pkg.sv
// Shared constants and parameter legality helpers for the counter_8b slice.
package counter_8b_pkg;

    localparam int unsigned COUNTER_DEFAULT_WIDTH = 8;
    localparam int unsigned COUNTER_MAX_WIDTH     = 32;

    function automatic bit width_ok(int unsigned w);
        return (w >= 1) && (w <= COUNTER_MAX_WIDTH);
    endfunction

    function automatic bit modulus_ok(int unsigned w, longint unsigned m);
        return (m >= 2) && (m <= (64'd1 << w));
    endfunction

    function automatic bit step_ok(longint unsigned s, longint unsigned m);
        return (s >= 1) && (s < m);
    endfunction

    function automatic bit reset_ok(longint unsigned rv, longint unsigned m);
        return rv < m;
    endfunction

endpackage

// File: rtl/counter_8b_if.sv
// Counter observation bundle: the counter drives count, consumers watch it.
interface counter_8b_if
    import counter_8b_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
    input logic clk
);

    logic             reset;
    logic [WIDTH-1:0] count;

    modport master (
        input  clk,
        input  reset,
        output count
    );

    modport slave (
        input clk,
        input reset,
        input count
    );

endinterface

// File: rtl/counter_8b_mod_adder.sv
// Combinational (a + STEP) mod MODULUS using a WIDTH+1 bit intermediate.
module mod_adder #(
    parameter int unsigned    WIDTH   = 8,
    parameter logic [WIDTH:0] STEP    = (WIDTH+1)'(1),
    parameter logic [WIDTH:0] MODULUS = {1'b1, {WIDTH{1'b0}}}
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] res;
    logic           unused_msb;

    // a < MODULUS and STEP < MODULUS, so sum < 2*MODULUS fits WIDTH+1 bits
    always_comb begin
        sum = {1'b0, a} + STEP;
        res = sum;
        if (sum >= MODULUS) begin
            res = sum - MODULUS;
        end
        y = res[WIDTH-1:0];
    end

    assign unused_msb = res[WIDTH];

endmodule

// File: rtl/counter_8b.sv
// Free-running modulo up-counter; async active-high reset, one register stage.
module counter_8b
    import counter_8b_pkg::*;
#(
    parameter int unsigned    WIDTH       = COUNTER_DEFAULT_WIDTH,
    parameter logic [WIDTH:0] RESET_VALUE = '0,
    parameter logic [WIDTH:0] STEP        = (WIDTH+1)'(1),
    parameter logic [WIDTH:0] MODULUS     = {1'b1, {WIDTH{1'b0}}}
) (
    output logic [WIDTH-1:0] count,
    input  logic             clk,
    input  logic             reset
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("counter_8b: WIDTH out of range 1..32");
    end
    if (!modulus_ok(WIDTH, 64'(MODULUS))) begin : g_bad_mod
        $error("counter_8b: MODULUS out of range 2..2**WIDTH");
    end
    if (!step_ok(64'(STEP), 64'(MODULUS))) begin : g_bad_step
        $error("counter_8b: STEP out of range 1..MODULUS-1");
    end
    if (!reset_ok(64'(RESET_VALUE), 64'(MODULUS))) begin : g_bad_rst
        $error("counter_8b: RESET_VALUE must be below MODULUS");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] next_val;

    mod_adder #(
        .WIDTH   (WIDTH),
        .STEP    (STEP),
        .MODULUS (MODULUS)
    ) u_mod_adder (
        .a (count_q),
        .y (next_val)
    );

    always_comb begin
        count_d = next_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VALUE[WIDTH-1:0];
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifndef SYNTHESIS
    logic rst_seen;

    always_ff @(posedge reset) begin
        rst_seen <= 1'b1;
    end

    // Sampled mid-cycle so async reset updates have settled
    always @(negedge clk) begin
        if (rst_seen === 1'b1) begin
            assert ({1'b0, count_q} < MODULUS)
                else $error("counter_8b: count out of range");
            if (reset) begin
                assert (count_q == RESET_VALUE[WIDTH-1:0])
                    else $error("counter_8b: count not held in reset");
            end
        end
    end
`endif

endmodule

// File: tb/tb_counter_8b.sv
// Directed and randomized checks of counter_8b against an arithmetic model.
module tb_counter_8b;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    longint n = 0;
    int   seq [0:10];

    counter_8b_if #(.WIDTH(8)) bus8 (.clk(clk));
    counter_8b_if #(.WIDTH(4)) bus4 (.clk(clk));

    assign bus8.reset = rst;
    assign bus4.reset = rst;

    counter_8b u_def (
        .count (bus8.count),
        .clk   (clk),
        .reset (bus8.reset)
    );

    counter_8b #(
        .WIDTH       (4),
        .RESET_VALUE (5'd2),
        .STEP        (5'd3),
        .MODULUS     (5'd10)
    ) u_mod (
        .count (bus4.count),
        .clk   (clk),
        .reset (bus4.reset)
    );

    always #10 clk = ~clk;

    // Value after k un-reset edges: (rv + k*step) mod m
    function automatic longint model(longint rv, longint step,
                                     longint m, longint k);
        return (rv + k * step) % m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        chk({tag, "_d8"}, 64'(bus8.count), 64'(model(0, 1, 256, n)));
        chk({tag, "_d4"}, 64'(bus4.count), 64'(model(2, 3, 10, n)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) n++;
    endtask

    // Called 1 ns after an edge; the pulse ends before the next falling edge
    task automatic pulse(input int a, input int b);
        #a rst = 1'b1;
        n = 0;
        #1 check_both("pulse");
        #b rst = 1'b0;
    endtask

    task automatic coincident();
        @(posedge clk);
        rst = 1'b1;
        n = 0;
        #1 check_both("coinc");
        #1 rst = 1'b0;
    endtask

    initial begin
        seq = '{2, 5, 8, 1, 4, 7, 0, 3, 6, 9, 2};
        rst = 1'b0;

        #5 rst = 1'b1;
        n = 0;
        #1 check_both("por");
        chk("por_zero", 64'(bus8.count), 64'd0);
        #3 rst = 1'b0;

        tick();
        chk("por_e1", 64'(bus8.count), 64'd1);
        check_both("e1");
        tick();
        chk("por_e2", 64'(bus8.count), 64'd2);

        repeat (254) begin
            tick();
            check_both("run");
        end
        chk("wrap256", 64'(bus8.count), 64'd0);
        repeat (4) tick();
        chk("wrap260", 64'(bus8.count), 64'd4);
        check_both("run260");

        pulse(2, 2);
        repeat (100) tick();
        chk("mid100", 64'(bus8.count), 64'd100);
        #5 rst = 1'b1;
        n = 0;
        #1 chk("mid_clr", 64'(bus8.count), 64'd0);
        check_both("mid_clr");
        #2 rst = 1'b0;
        tick();
        chk("mid_e1", 64'(bus8.count), 64'd1);

        rst = 1'b1;
        n = 0;
        repeat (5) begin
            tick();
            chk("held", 64'(bus8.count), 64'd0);
            check_both("held");
        end
        rst = 1'b0;

        pulse(1, 1);
        chk("seq0", 64'(bus4.count), 64'(seq[0]));
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("seq", 64'(bus4.count), 64'(seq[i]));
        end

        pulse(1, 1);
        repeat (7) tick();
        chk("pre7", 64'(bus8.count), 64'd7);
        coincident();
        chk("coinc0", 64'(bus8.count), 64'd0);

        repeat (40) begin
            case ($urandom_range(0, 2))
                0: repeat ($urandom_range(1, 40)) begin
                    tick();
                    check_both("rnd");
                end
                1: pulse(int'($urandom_range(1, 4)),
                         int'($urandom_range(1, 3)));
                default: coincident();
            endcase
        end
        tick();
        check_both("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
